excess3_conv_sched: RTL and testbench
=====================================

EXCESS3_CONV_SCHED -- requirements
Module: excess3_conv_sched

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of excess-3 digits per request word (range 1..8).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port req0_valid, input, 1, requester 0 has a word.
REQ-005 The block SHALL have port req0_data, input, 4*DIGITS, requester 0 excess-3 word, digit 0 in bits [3:0].
REQ-006 The block SHALL have port req0_ready, output, 1, requester 0 word accepted this cycle when high with req0_valid.
REQ-007 The block SHALL have ports req1_valid, req1_data and req1_ready, identical to the requester 0 ports, for requester 1.
REQ-008 The block SHALL have port out_valid, output, 1, result available.
REQ-009 The block SHALL have port out_data, output, 4*DIGITS, BCD result in the same digit order as the input word.
REQ-010 The block SHALL have port out_id, output, 1, index of the requester that owns the result.
REQ-011 The block SHALL have port out_err, output, 1, result contains an invalid excess-3 digit.
REQ-012 The block SHALL have port out_ready, input, 1, consumer takes the result.
REQ-013 The block SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 The block SHALL implement the states IDLE, CONV and DONE, with one conversion datapath shared by both requesters.
REQ-015 In IDLE, the block SHALL raise the ready of exactly one granted requester; no ready is raised in CONV or DONE.
REQ-016 Grant SHALL be round-robin: if one valid is high, that requester is granted; if both are high, the requester not granted last is granted.
REQ-017 On an accept edge, the block SHALL capture the word and the id, clear the digit index and out_err, and move to CONV.
REQ-018 In CONV, each edge SHALL convert digit[idx] (BCD = code minus 3, mod 16), write it into the result register and increment idx.
REQ-019 At idx = DIGITS-1, the block SHALL move to DONE, so out_valid rises exactly DIGITS edges after the accept edge.
REQ-020 In DONE, out_valid, out_data, out_id and out_err SHALL hold stable until an edge with out_ready high, then the block SHALL return to IDLE.
REQ-021 An edge with out_ready high in DONE SHALL not accept a new word; the earliest next accept is the following edge.
REQ-022 out_data, out_id and out_err SHALL be valid only while out_valid is high.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, idx=0, result=0, out_valid=0, out_err=0, out_id=0 and busy=0, and SHALL set the last-grant pointer to 1 so requester 0 wins the first tie.
REQ-024 Reset during CONV or DONE SHALL abandon the word in flight with no output.

Configuration
REQ-025 With macro EXCESS3_ERR_CHECK_EN defined, out_err SHALL be set when any converted digit is below 0011 or above 1100; the conversion result is still written.
REQ-026 Without EXCESS3_ERR_CHECK_EN, out_err SHALL be constant 0 and no check logic SHALL exist.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, CONV, DONE), the excess-3 offset constant 3, and the valid-range bounds 3 and 12.
REQ-028 The combinational 4-bit conversion SHALL be a single sub-module, excess3_digit_conv (4-bit in, 4-bit out), instantiated once.

Verification (DIGITS=4)
REQ-029 The bench SHALL cover: req0 word 0x4567, out_ready=1 -> out_valid 4 edges after accept, out_data=0x1234, out_id=0, out_err=0.
REQ-030 The bench SHALL cover: both valid after reset, req0=0x3333 and req1=0xCCCC -> req0 served first (0x0000), then req1 (0x9999, out_id=1).
REQ-031 The bench SHALL cover: req1 held valid continuously while req0 is re-asserted -> grants alternate 0,1,0,1.
REQ-032 The bench SHALL cover: out_ready held low for 10 cycles in DONE -> outputs stable, both readys low, busy=1.
REQ-033 The bench SHALL cover: word 0x45F7 -> with EXCESS3_ERR_CHECK_EN, out_err=1 and out_data=0x12C4; without the macro, out_err=0.
REQ-034 The bench SHALL cover: rst pulsed on the second CONV edge -> out_valid stays 0, the block is in IDLE, and the next accept produces a correct result.

Source files
------------

// File: rtl/excess3_conv_sched_pkg.sv
// Shared types and constants for the excess-3 to BCD conversion scheduler.
package excess3_conv_sched_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam logic [3:0] XS3_OFFSET = 4'd3;
   localparam logic [3:0] XS3_MIN    = 4'd3;
   localparam logic [3:0] XS3_MAX    = 4'd12;

endpackage

// File: rtl/excess3_digit_conv.sv
// Single-digit excess-3 to BCD conversion (code minus 3, mod 16).
module excess3_digit_conv
   import excess3_conv_sched_pkg::*;
(
   input  logic [3:0] code,
   output logic [3:0] bcd
);

   assign bcd = code - XS3_OFFSET;

endmodule

// File: rtl/excess3_conv_sched.sv
// Two-requester round-robin excess-3 to BCD converter, one digit per cycle.
// Define EXCESS3_ERR_CHECK_EN to flag words holding invalid excess-3 digits.
module excess3_conv_sched
   import excess3_conv_sched_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [4*DIGITS-1:0]   req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [4*DIGITS-1:0]   req1_data,
   output logic                  req1_ready,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   out_data,
   output logic                  out_id,
   output logic                  out_err,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [W-1:0]    word;
   logic [W-1:0]    result;
   logic            last;
   logic            id_q;
   logic            valid_q;
   logic            grant0;
   logic            grant1;
   logic [3:0]      code;
   logic [3:0]      bcd;

   // last==1 means requester 1 was served most recently, so 0 wins a tie
   assign grant0 = (state == IDLE) && req0_valid && (!req1_valid || last);
   assign grant1 = (state == IDLE) && req1_valid && !grant0;

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign busy       = (state != IDLE);
   assign out_valid  = valid_q;
   assign out_data   = result;
   assign out_id     = id_q;

   assign code = 4'(word >> {idx, 2'b00});

   excess3_digit_conv u_conv (
      .code (code),
      .bcd  (bcd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         word    <= '0;
         result  <= '0;
         last    <= 1'b1;
         id_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  word  <= grant1 ? req1_data : req0_data;
                  id_q  <= grant1;
                  last  <= grant1;
                  idx   <= '0;
                  state <= CONV;
               end
            end
            CONV: begin
               result[{idx, 2'b00} +: 4] <= bcd;
               idx <= idx + 1'b1;
               if (idx == IW'(DIGITS - 1)) begin
                  state   <= DONE;
                  valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state   <= IDLE;
                  valid_q <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef EXCESS3_ERR_CHECK_EN
   logic err_q;
   logic bad;

   assign bad = (code < XS3_MIN) || (code > XS3_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state == IDLE && (grant0 || grant1)) begin
         err_q <= 1'b0;
      end else if (state == CONV && bad) begin
         err_q <= 1'b1;
      end
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_excess3_conv_sched.sv
// Randomized and directed self-checking bench for excess3_conv_sched.
module tb_excess3_conv_sched;

   localparam int DIGITS = 4;
   localparam int W = 4 * DIGITS;
`ifdef EXCESS3_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0;
   logic [W-1:0] req0_data = '0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [W-1:0] req1_data = '0;
   logic         req1_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_id;
   logic         out_err;
   logic         out_ready = 1'b0;
   logic         busy;

   int checks = 0;
   int errors = 0;

   excess3_conv_sched #(.DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_id     (out_id),
      .out_err    (out_err),
      .out_ready  (out_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic logic [W-1:0] to_bcd(input logic [W-1:0] w);
      logic [W-1:0] r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         int c = int'((w >> (4 * i)) & 16'hF);
         r = r | (W'((c + 13) % 16) << (4 * i));
      end
      return r;
   endfunction

   function automatic logic has_bad(input logic [W-1:0] w);
      logic b = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         int c = int'((w >> (4 * i)) & 16'hF);
         if (c < 3 || c > 12) b = 1'b1;
      end
      return b && ERR_EN;
   endfunction

   // transaction-level reference: idle / converting(countdown) / holding result
   logic         m_busy, m_valid, m_last, m_id, m_err;
   logic [W-1:0] m_data;
   int           m_wait;
   logic         e_g0, e_g1;

   assign e_g0 = !m_busy && req0_valid && (!req1_valid || m_last);
   assign e_g1 = !m_busy && req1_valid && !e_g0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy  <= 1'b0;
         m_valid <= 1'b0;
         m_last  <= 1'b1;
         m_id    <= 1'b0;
         m_err   <= 1'b0;
         m_data  <= '0;
         m_wait  <= 0;
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
         end
      end else if (m_busy) begin
         m_wait <= m_wait - 1;
         if (m_wait == 1) m_valid <= 1'b1;
      end else if (e_g0 || e_g1) begin
         m_busy <= 1'b1;
         m_wait <= DIGITS;
         m_id   <= e_g1;
         m_last <= e_g1;
         m_data <= to_bcd(e_g1 ? req1_data : req0_data);
         m_err  <= has_bad(e_g1 ? req1_data : req0_data);
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_valid", 32'(out_valid), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_data", 32'(out_data), 0);
         chk("rst_id", 32'(out_id), 0);
         chk("rst_err", 32'(out_err), 0);
      end else begin
         chk("ready0", 32'(req0_ready), 32'(e_g0));
         chk("ready1", 32'(req1_ready), 32'(e_g1));
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         chk("busy", 32'(busy), 32'(m_busy));
         if (m_valid) begin
            chk("out_data", 32'(out_data), 32'(m_data));
            chk("out_id", 32'(out_id), 32'(m_id));
            chk("out_err", 32'(out_err), 32'(m_err));
         end
      end
   end

   int grants[$];
   always @(posedge clk) begin
      if (!rst && req0_valid && req0_ready) grants.push_back(0);
      if (!rst && req1_valid && req1_ready) grants.push_back(1);
   end

   task automatic send(input int r, input logic [W-1:0] d);
      bit ok = 1'b0;
      if (r == 0) begin
         req0_data = d; req0_valid = 1'b1;
      end else begin
         req1_data = d; req1_valid = 1'b1;
      end
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if ((r == 0) ? req0_ready : req1_ready) ok = 1'b1;
      end
      @(posedge clk);
      #1;
      if (r == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
      chk("accept_timeout", 32'(ok), 1);
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         k++;
         if (out_valid) return;
      end
      chk("valid_timeout", 32'(out_valid), 1);
   endtask

   initial begin
      int k;
      logic [W-1:0] snap;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      out_ready = 1'b1;

      // 0x4567 -> 0x1234 four edges after accept
      send(0, 16'h4567);
      wait_valid(k);
      chk("lat_4567", 32'(k), 4);
      chk("data_4567", 32'(out_data), 32'h1234);
      chk("id_4567", 32'(out_id), 0);
      chk("err_4567", 32'(out_err), 0);
      @(posedge clk); #1;

      // tie after reset: requester 0 first
      rst = 1'b1; #2 rst = 1'b0;
      req0_data = 16'h3333; req1_data = 16'hCCCC;
      req0_valid = 1'b1; req1_valid = 1'b1;
      wait_valid(k);
      chk("tie_first_data", 32'(out_data), 32'h0000);
      chk("tie_first_id", 32'(out_id), 0);
      @(posedge clk); #1;
      wait_valid(k);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("tie_second_data", 32'(out_data), 32'h9999);
      chk("tie_second_id", 32'(out_id), 1);
      @(posedge clk); #1;

      // both held: grants alternate
      grants.delete();
      req0_data = 16'h4444; req1_data = 16'h5555;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 100 && grants.size() < 4; i++) begin
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_count", 32'(grants.size()), 4);
      if (grants.size() >= 4) begin
         chk("rr_g0", 32'(grants[0]), 0);
         chk("rr_g1", 32'(grants[1]), 1);
         chk("rr_g2", 32'(grants[2]), 0);
         chk("rr_g3", 32'(grants[3]), 1);
      end
      repeat (8) @(posedge clk);
      #1;

      // stall in DONE for 10 cycles
      out_ready = 1'b0;
      send(0, 16'h5678);
      wait_valid(k);
      snap = out_data;
      chk("stall_data0", 32'(snap), 32'h2345);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_data", 32'(out_data), 32'h2345);
         chk("stall_rdy", 32'({req0_ready, req1_ready}), 0);
         chk("stall_busy", 32'(busy), 1);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release", 32'(out_valid), 0);

      // invalid digit
      send(1, 16'h45F7);
      wait_valid(k);
      chk("bad_data", 32'(out_data), 32'h12C4);
      chk("bad_err", 32'(out_err), 32'(ERR_EN));
      @(posedge clk); #1;

      // reset on the second CONV edge abandons the word
      send(0, 16'h9876);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(out_valid), 0);
      k = 0;
      repeat (10) begin
         @(posedge clk); #1;
         if (out_valid) k++;
      end
      chk("abort_no_out", 32'(k), 0);
      send(0, 16'h3C5A);
      wait_valid(k);
      chk("after_abort", 32'(out_data), 32'h0927);
      @(posedge clk); #1;

      // random traffic against the model
      for (int c = 0; c < 1500; c++) begin
         req0_valid = 1'($urandom % 2);
         req1_valid = 1'($urandom % 2);
         out_ready = ($urandom % 4) != 0;
         for (int i = 0; i < DIGITS; i++) begin
            req0_data[4*i +: 4] = ($urandom % 5 == 0) ? 4'($urandom)
                                  : 4'(3 + $urandom % 10);
            req1_data[4*i +: 4] = ($urandom % 5 == 0) ? 4'($urandom)
                                  : 4'(3 + $urandom % 10);
         end
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
